// File: rtl/argsel_pkg.sv
// Shared definitions for the streaming arg-max/arg-min reducer.
// Holds the compare-mode constants and the FSM state encoding.
package argsel_pkg;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/argsel_cmp.sv
// Strict max/min replace decision between a held value and a candidate.
// Ports: a (held best), b (candidate), mode (0 max, 1 min) -> take_b.
module argsel_cmp
  import argsel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             take_b
);

  logic gt;
  logic lt;

  // Strict compares only: equal values never replace,
  // so ties keep the earlier (lower) index.
  always_comb begin
    if (SIGNED) begin
      gt = $signed(b) > $signed(a);
      lt = $signed(b) < $signed(a);
    end else begin
      gt = b > a;
      lt = b < a;
    end
    take_b = (mode == MODE_MIN) ? lt : gt;
  end

endmodule

// File: rtl/argsel_stream.sv
// Streaming arg-max/arg-min over frames of 1..2^IDX_W samples.
// Ports: clk, rst (sync, high); mode, in_valid/in_ready, in_data,
// in_last in; out_valid/out_ready, out_data, out_idx, out_count,
// out_trunc out. Result is held until the consumer takes it.
module argsel_stream
  import argsel_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1,
  parameter int IDX_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count,
  output logic             out_trunc
);

  localparam logic [IDX_W:0] DEPTH =
    {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] ONE =
    (IDX_W+1)'(1);

  state_t state;
  state_t state_d;

  logic [WIDTH-1:0] best;
  logic [IDX_W-1:0] best_idx;
  logic [IDX_W:0]   cnt;
  logic             mode_q;

  logic             acc;
  logic             first;
  logic             take;
  logic             full;
  logic             close;
  logic             trunc_d;
  logic [WIDTH-1:0] best_d;
  logic [IDX_W-1:0] idx_d;
  logic [IDX_W:0]   cnt_d;

  argsel_cmp #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a      (best),
    .b      (in_data),
    .mode   (mode_q),
    .take_b (take)
  );

  assign in_ready  = (state != ST_HOLD);
  assign out_valid = (state == ST_HOLD);

  // Datapath next values for the sample being accepted.
  // The new sample's index equals the count before it.
  always_comb begin
    acc     = in_valid && in_ready;
    first   = (state == ST_IDLE);
    best_d  = best;
    idx_d   = best_idx;
    cnt_d   = cnt + ONE;
    if (first) begin
      best_d = in_data;
      idx_d  = '0;
      cnt_d  = ONE;
    end else if (take) begin
      best_d = in_data;
      idx_d  = cnt[IDX_W-1:0];
    end
    full    = (cnt_d == DEPTH);
    close   = acc && (in_last || full);
    trunc_d = full && !in_last;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE: begin
        if (acc) state_d = close ? ST_HOLD : ST_ACC;
      end
      ST_ACC: begin
        if (close) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best     <= '0;
      best_idx <= '0;
      cnt      <= '0;
      mode_q   <= MODE_MAX;
    end else if (acc) begin
      best     <= best_d;
      best_idx <= idx_d;
      cnt      <= cnt_d;
      if (first) mode_q <= mode;
    end
  end

  // Result registers load only when a frame closes.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_idx   <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
    end else if (close) begin
      out_data  <= best_d;
      out_idx   <= idx_d;
      out_count <= cnt_d;
      out_trunc <= trunc_d;
    end
  end

endmodule

// File: tb/tb_argsel_stream.sv
// Randomized and directed bench for argsel_stream, signed and
// unsigned instances side by side against a frame-level model.
module tb_argsel_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_ready;

  logic        ir_s, ov_s, tr_s;
  logic [31:0] od_s;
  logic [2:0]  oi_s;
  logic [3:0]  oc_s;
  logic        ir_u, ov_u, tr_u;
  logic [31:0] od_u;
  logic [2:0]  oi_u;
  logic [3:0]  oc_u;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] ds;
    int          is;
    logic [31:0] du;
    int          iu;
    int          cnt;
    bit          tr;
  } res_t;

  logic [31:0] cur[$];
  bit          cur_m;
  bit          pend;
  res_t        er;

  always #5 clk = ~clk;

  argsel_stream #(.WIDTH(32), .SIGNED(1'b1), .IDX_W(3)) u_dut_s (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_s),
    .in_data(in_data), .in_last(in_last),
    .out_valid(ov_s), .out_ready(out_ready),
    .out_data(od_s), .out_idx(oi_s),
    .out_count(oc_s), .out_trunc(tr_s)
  );

  argsel_stream #(.WIDTH(32), .SIGNED(1'b0), .IDX_W(3)) u_dut_u (
    .clk(clk), .rst(rst), .mode(mode),
    .in_valid(in_valid), .in_ready(ir_u),
    .in_data(in_data), .in_last(in_last),
    .out_valid(ov_u), .out_ready(out_ready),
    .out_data(od_u), .out_idx(oi_u),
    .out_count(oc_u), .out_trunc(tr_u)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Index of the first extreme element of a frame.
  function automatic int pick(input logic [31:0] f[$],
                              input bit mn, input bit sg);
    int b = 0;
    for (int i = 1; i < f.size(); i++) begin
      bit better;
      if (sg)
        better = mn ? ($signed(f[i]) < $signed(f[b]))
                    : ($signed(f[i]) > $signed(f[b]));
      else
        better = mn ? (f[i] < f[b]) : (f[i] > f[b]);
      if (better) b = i;
    end
    return b;
  endfunction

  // One clock: check outputs against model, drive, advance.
  task automatic step(input bit v, input logic [31:0] d,
                      input bit l, input bit m, input bit ordy,
                      output bit accepted);
    bit hs;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    mode      = m;
    out_ready = ordy;
    chk("in_ready_s", ir_s, !pend);
    chk("in_ready_u", ir_u, !pend);
    chk("out_valid_s", ov_s, pend);
    chk("out_valid_u", ov_u, pend);
    if (pend) begin
      chk("data_s", od_s, er.ds);
      chk("idx_s", oi_s, er.is);
      chk("data_u", od_u, er.du);
      chk("idx_u", oi_u, er.iu);
      chk("count_s", oc_s, er.cnt);
      chk("count_u", oc_u, er.cnt);
      chk("trunc_s", tr_s, er.tr);
      chk("trunc_u", tr_u, er.tr);
    end
    hs = pend && ordy;
    accepted = v && !pend;
    if (hs) pend = 0;
    if (accepted) begin
      if (cur.size() == 0) cur_m = m;
      cur.push_back(d);
      if (l || cur.size() == 8) begin
        er.is  = pick(cur, cur_m, 1'b1);
        er.ds  = cur[er.is];
        er.iu  = pick(cur, cur_m, 1'b0);
        er.du  = cur[er.iu];
        er.cnt = cur.size();
        er.tr  = !l;
        pend   = 1;
        cur.delete();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit l,
                      input bit m);
    bit a = 0;
    for (int k = 0; k < 20 && !a; k++)
      step(1'b1, d, l, m, 1'b1, a);
    if (!a) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int k = 0; k < n; k++)
      step(1'b0, 32'h0, 1'b0, 1'b0, ordy, a);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h5a5a5a5a;
    in_last  = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    cur.delete();
    pend = 0;
  endtask

  task automatic expect_s(input string t, input logic [31:0] d,
                          input int i, input int c, input bit tr);
    chk({t, "_v"}, ov_s, 1);
    chk({t, "_d"}, od_s, d);
    chk({t, "_i"}, oi_s, i);
    chk({t, "_c"}, oc_s, c);
    chk({t, "_t"}, tr_s, tr);
  endtask

  initial begin
    bit a;
    rst = 1'b0; mode = 1'b0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    pend = 0; cur_m = 0;
    #2;
    do_reset();
    chk("rst_valid", ov_s, 0);
    chk("rst_data", od_s, 0);
    chk("rst_idx", oi_s, 0);
    chk("rst_count", oc_s, 0);
    chk("rst_trunc", tr_s, 0);
    chk("rst_ready", ir_s, 1);

    // max, signed
    send(5, 0, 0); send(-3, 0, 0); send(17, 0, 0); send(2, 1, 0);
    expect_s("max", 17, 2, 4, 0);
    idle(2, 1);

    // min with tie
    send(4, 0, 1); send(1, 0, 1); send(9, 0, 1); send(1, 1, 1);
    expect_s("tie", 1, 1, 4, 0);
    idle(2, 1);

    // signedness
    send(32'h80000000, 0, 0); send(1, 1, 0);
    expect_s("sgn", 1, 1, 2, 0);
    chk("uns_d", od_u, 32'h80000000);
    chk("uns_i", oi_u, 0);
    idle(2, 1);

    // single sample with backpressure
    send(7, 1, 0);
    for (int k = 0; k < 5; k++) begin
      expect_s("bp", 7, 0, 1, 0);
      chk("bp_rdy", ir_s, 0);
      step(1'b0, 0, 0, 0, 1'b0, a);
    end
    step(1'b0, 0, 0, 0, 1'b1, a);
    chk("bp_after", ir_s, 1);
    idle(1, 1);

    // truncation
    for (int k = 0; k < 8; k++) send(k, 0, 0);
    expect_s("trn", 7, 7, 8, 1);
    send(8, 0, 0); send(9, 1, 0);
    expect_s("trn2", 9, 1, 2, 0);
    idle(2, 1);

    // mid-frame reset, then mode latch
    send(100, 0, 0); send(200, 0, 0);
    do_reset();
    chk("abort_v", ov_s, 0);
    idle(2, 1);
    send(3, 0, 0); send(8, 1, 1);
    expect_s("latch", 8, 1, 2, 0);
    idle(2, 1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0: d = $urandom;
        1: d = 32'($signed($urandom_range(0, 8)) - 4);
        2: d = $urandom_range(0, 1) ? 32'h80000000 : 32'h7fffffff;
        default: d = $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 599) == 0) do_reset();
      else
        step($urandom_range(0, 3) != 0, d,
             $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3) != 0, a);
    end
    idle(3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
